// File: rtl/bit_serializer_feed_pkg.sv
// Shared constants for the serial feeder: state encoding and counter sizing.
package bit_serializer_feed_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit counter width for a word of w bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_feed.sv
// Parallel-to-serial feeder for the pattern detector: one bit per clock on w_o,
// idle level between words, back-to-back words reloaded on the last-bit cycle.
module bit_serializer_feed
    import bit_serializer_feed_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rs_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             w_o,
    output logic             w_valid_o,
    output logic             last_bit_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_bit;
    logic             cnt_zero;
    logic             take;

    assign cnt_zero    = (cnt_q == '0);
    assign out_bit     = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign din_ready_o = rs_i && ((state_q == ST_IDLE) || cnt_zero);
    assign take        = din_valid_i && din_ready_o;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    sh_d    = din_i;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
                cnt_d = cnt_q - CW'(1);
                if (cnt_zero) begin
                    // Reload on the last bit so consecutive words have no gap.
                    if (take) begin
                        sh_d  = din_i;
                        cnt_d = CW'(WIDTH - 1);
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rs_i) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_o        = (state_q == ST_SHIFT) ? out_bit : IDLE_BIT;
    assign w_valid_o  = (state_q == ST_SHIFT);
    assign last_bit_o = (state_q == ST_SHIFT) && cnt_zero;
    assign busy_o     = (state_q == ST_SHIFT);

endmodule
